// File: rtl/velocity_bar_renderer_pkg.sv
// Shared constants for the visualiser pixel path: per-instrument bar colours,
// marker/background colours and the pixel-coordinate widths.
package viz_pkg;

    localparam int HCOUNT_W        = 11;
    localparam int VCOUNT_W        = 10;
    localparam int VEL_W           = 7;
    localparam int MAX_INSTRUMENTS = 8;

    localparam logic [23:0] BAR_COLOR [MAX_INSTRUMENTS] = '{
        24'hFF3030,  // bd
        24'h30FF30,  // sd
        24'h3030FF,  // hh
        24'hFFFF30,
        24'h30FFFF,
        24'hFF30FF,
        24'hFF9030,
        24'h9030FF
    };

    localparam logic [23:0] PEAK_COLOR = 24'hFFFFFF;
    localparam logic [23:0] BG_COLOR   = 24'h000000;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        return BAR_COLOR[idx];
    endfunction

endpackage

// File: rtl/velocity_bar_renderer_peak_hold.sv
// Per-instrument peak tracker: a new maximum is latched and held for a number
// of frames, then decays by a fixed step each frame.
module peak_hold #(
    parameter int HOLD_FRAMES = 30,
    parameter int FALL        = 1
) (
    input  logic       clk_pixel,
    input  logic       rst,
    input  logic       new_frame,
    input  logic [6:0] v,
    output logic [6:0] peak
);

    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    logic [6:0]        peak_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            peak_reg     <= '0;
            hold_cnt_reg <= '0;
        end else if (new_frame) begin
            if (v >= peak_reg) begin
                peak_reg     <= v;
                hold_cnt_reg <= HOLD_W'(HOLD_FRAMES);
            end else if (hold_cnt_reg != '0) begin
                hold_cnt_reg <= hold_cnt_reg - 1'b1;
            end else begin
                peak_reg <= (peak_reg > 7'(FALL)) ? peak_reg - 7'(FALL) : 7'd0;
            end
        end
    end

    assign peak = peak_reg;

endmodule

// File: rtl/velocity_bar_renderer.sv
// Velocity bar-graph overlay: per-frame velocity snapshots, peak markers and a
// two-stage pixel colour pipeline driven by hcount/vcount.
module velocity_bar_renderer
    import viz_pkg::*;
#(
    parameter int INSTRUMENT_COUNT = 3,
    parameter int X_ORIGIN         = 64,
    parameter int BAR_WIDTH        = 64,
    parameter int BAR_GAP          = 32,
    parameter int Y_BASE           = 680,
    parameter int HEIGHT_SHIFT     = 2,
    parameter int PEAK_HOLD_FRAMES = 30,
    parameter int PEAK_FALL        = 1,
    parameter int PEAK_THICK       = 4
) (
    input  logic                clk_pixel,
    input  logic                rst,
    input  logic                new_frame,
    input  logic [VEL_W-1:0]    inst_velocity [INSTRUMENT_COUNT],
    input  logic [HCOUNT_W-1:0] hcount,
    input  logic [VCOUNT_W-1:0] vcount,
    output logic [7:0]          red,
    output logic [7:0]          green,
    output logic [7:0]          blue
);

    localparam int          STRIDE       = BAR_WIDTH + BAR_GAP;
    localparam logic [10:0] Y_BASE_L     = 11'(Y_BASE);
    localparam logic [10:0] PEAK_THICK_L = 11'(PEAK_THICK);

    logic [VEL_W-1:0] vel_snap_reg [INSTRUMENT_COUNT];
    logic [VEL_W-1:0] peak         [INSTRUMENT_COUNT];
    logic [10:0]      bar_top_reg  [INSTRUMENT_COUNT];
    logic [10:0]      peak_top_reg [INSTRUMENT_COUNT];
    logic [INSTRUMENT_COUNT-1:0] bar_nz_reg;
    logic [INSTRUMENT_COUNT-1:0] peak_nz_reg;
    logic [INSTRUMENT_COUNT-1:0] col_hit;
    logic [INSTRUMENT_COUNT-1:0] peak_hit;
    logic [INSTRUMENT_COUNT-1:0] bar_hit;
    logic                        new_frame_d_reg;
    logic [10:0]                 vcount_ext;

    assign vcount_ext = {1'b0, vcount};

    for (genvar gi = 0; gi < INSTRUMENT_COUNT; gi++) begin : g_inst
        localparam logic [10:0] X_LO = 11'(X_ORIGIN + gi * STRIDE);
        localparam logic [10:0] X_HI = 11'(X_ORIGIN + gi * STRIDE + BAR_WIDTH - 1);

        peak_hold #(
            .HOLD_FRAMES (PEAK_HOLD_FRAMES),
            .FALL        (PEAK_FALL)
        ) u_peak_hold (
            .clk_pixel (clk_pixel),
            .rst       (rst),
            .new_frame (new_frame),
            .v         (inst_velocity[gi]),
            .peak      (peak[gi])
        );

        // Tops are refreshed the cycle after the snapshot so they see the new
        // velocity and peak; the nonzero flags suppress zero-height drawing.
        always_ff @(posedge clk_pixel) begin
            if (rst) begin
                vel_snap_reg[gi] <= '0;
                bar_top_reg[gi]  <= '0;
                peak_top_reg[gi] <= '0;
                bar_nz_reg[gi]   <= 1'b0;
                peak_nz_reg[gi]  <= 1'b0;
            end else begin
                if (new_frame) begin
                    vel_snap_reg[gi] <= inst_velocity[gi];
                end
                if (new_frame_d_reg) begin
                    bar_top_reg[gi]  <= Y_BASE_L - ({4'b0, vel_snap_reg[gi]} << HEIGHT_SHIFT);
                    peak_top_reg[gi] <= Y_BASE_L - ({4'b0, peak[gi]} << HEIGHT_SHIFT);
                    bar_nz_reg[gi]   <= |vel_snap_reg[gi];
                    peak_nz_reg[gi]  <= |peak[gi];
                end
            end
        end

        assign col_hit[gi]  = (hcount >= X_LO) && (hcount <= X_HI);
        assign peak_hit[gi] = peak_nz_reg[gi] && (vcount_ext <= peak_top_reg[gi])
                              && (vcount_ext + PEAK_THICK_L > peak_top_reg[gi]);
        assign bar_hit[gi]  = bar_nz_reg[gi] && (vcount_ext > bar_top_reg[gi])
                              && (vcount_ext <= Y_BASE_L);
    end

    logic [2:0] sel_idx;
    logic       sel_hit;
    logic       sel_peak;
    logic       sel_bar;

    always_comb begin
        sel_idx  = '0;
        sel_hit  = 1'b0;
        sel_peak = 1'b0;
        sel_bar  = 1'b0;
        for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
            if (col_hit[i]) begin
                sel_idx  = 3'(i);
                sel_hit  = 1'b1;
                sel_peak = peak_hit[i];
                sel_bar  = bar_hit[i];
            end
        end
    end

    logic [2:0]  s1_idx_reg;
    logic        s1_hit_reg;
    logic        s1_peak_reg;
    logic        s1_bar_reg;
    logic [23:0] color_reg;

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            new_frame_d_reg <= 1'b0;
            s1_idx_reg      <= '0;
            s1_hit_reg      <= 1'b0;
            s1_peak_reg     <= 1'b0;
            s1_bar_reg      <= 1'b0;
            color_reg       <= BG_COLOR;
        end else begin
            new_frame_d_reg <= new_frame;
            s1_idx_reg      <= sel_idx;
            s1_hit_reg      <= sel_hit;
            s1_peak_reg     <= sel_peak;
            s1_bar_reg      <= sel_bar;
            if (!s1_hit_reg) begin
                color_reg <= BG_COLOR;
            end else if (s1_peak_reg) begin
                color_reg <= PEAK_COLOR;
            end else if (s1_bar_reg) begin
                color_reg <= bar_color(s1_idx_reg);
            end else begin
                color_reg <= BG_COLOR;
            end
        end
    end

    assign red   = color_reg[23:16];
    assign green = color_reg[15:8];
    assign blue  = color_reg[7:0];

endmodule

// File: tb/tb_velocity_bar_renderer.sv
// Directed bench for velocity_bar_renderer: bar geometry, snapshot stability,
// reset behaviour, peak hold/fall and re-hit handling with default parameters.
module tb_velocity_bar_renderer;

    logic        clk_pixel = 1'b0;
    logic        rst = 1'b1;
    logic        new_frame = 1'b0;
    logic [6:0]  inst_velocity [3];
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [23:0] RED   = 24'hFF3030;
    localparam logic [23:0] GREEN = 24'h30FF30;
    localparam logic [23:0] BLUE  = 24'h3030FF;
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BLACK = 24'h000000;

    always #5 clk_pixel = ~clk_pixel;

    velocity_bar_renderer dut (
        .clk_pixel     (clk_pixel),
        .rst           (rst),
        .new_frame     (new_frame),
        .inst_velocity (inst_velocity),
        .hcount        (hcount),
        .vcount        (vcount),
        .red           (red),
        .green         (green),
        .blue          (blue)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
            $display("ok   %s: observed %06h", tag, obs);
        else begin
            n_err++;
            $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
        end
    endtask

    // Present one pixel for one cycle, then a background pixel, so the sample
    // taken two cycles later only matches with exactly two cycles of latency.
    task automatic pix(input logic [10:0] h, input logic [9:0] v,
                       input logic [23:0] exp, input string tag);
        @(posedge clk_pixel); #1;
        hcount = h;
        vcount = v;
        @(posedge clk_pixel); #1;
        hcount = '0;
        vcount = '0;
        @(posedge clk_pixel); #1;
        check_val(tag, {8'h0, red, green, blue}, {8'h0, exp});
    endtask

    task automatic frame();
        @(posedge clk_pixel); #1;
        new_frame = 1'b1;
        @(posedge clk_pixel); #1;
        new_frame = 1'b0;
        repeat (2) @(posedge clk_pixel);
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    task automatic do_reset();
        @(posedge clk_pixel); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk_pixel);
        #1 rst = 1'b0;
    endtask

    task automatic scan_row(input logic [9:0] v, input string tag);
        int bad;
        bad = 0;
        vcount = v;
        for (int x = 0; x < 1284; x++) begin
            @(posedge clk_pixel); #1;
            hcount = (x < 1280) ? 11'(x) : 11'd0;
            if ({red, green, blue} !== BLACK) bad++;
        end
        check_val(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) inst_velocity[i] = '0;
        repeat (3) @(posedge clk_pixel);
        #1 rst = 1'b0;

        // Bar draw, instrument 0 at velocity 100: bar 281..680, marker 277..280
        pix(11'd100, 10'd300, BLACK, "idle_before_frame");
        inst_velocity[0] = 7'd100;
        frame();
        pix(11'd100, 10'd300, RED,   "bar0_mid");
        pix(11'd100, 10'd279, WHITE, "bar0_marker");
        pix(11'd100, 10'd277, WHITE, "bar0_marker_top");
        pix(11'd100, 10'd276, BLACK, "bar0_above_marker");
        pix(11'd100, 10'd281, RED,   "bar0_top_row");
        pix(11'd100, 10'd680, RED,   "bar0_base_row");
        pix(11'd100, 10'd681, BLACK, "bar0_below_base");
        pix(11'd140, 10'd300, BLACK, "gap_0_1");
        pix(11'd64,  10'd300, RED,   "bar0_left_edge");
        pix(11'd127, 10'd300, RED,   "bar0_right_edge");
        pix(11'd63,  10'd300, BLACK, "left_of_bar0");
        pix(11'd128, 10'd300, BLACK, "right_of_bar0");

        // Snapshot stability on instrument 1
        inst_velocity[1] = 7'd127;
        pix(11'd190, 10'd300, BLACK, "snap_stable_col1");
        pix(11'd190, 10'd600, BLACK, "snap_stable_col1_low");
        frame();
        pix(11'd190, 10'd173, GREEN, "bar1_top_row");
        pix(11'd190, 10'd172, WHITE, "bar1_marker");
        pix(11'd190, 10'd168, BLACK, "bar1_above_marker");
        pix(11'd160, 10'd680, GREEN, "bar1_left_base");
        pix(11'd223, 10'd300, GREEN, "bar1_right_edge");
        pix(11'd224, 10'd300, BLACK, "right_of_bar1");
        pix(11'd100, 10'd300, RED,   "bar0_still_red");

        // Reset with nonzero velocities while a red pixel is streaming
        hcount = 11'd100;
        vcount = 10'd300;
        repeat (3) @(posedge clk_pixel);
        #1 check_val("pre_reset_red", {8'h0, red, green, blue}, {8'h0, RED});
        rst = 1'b1;
        @(posedge clk_pixel); #1;
        check_val("reset_black", {8'h0, red, green, blue}, {8'h0, BLACK});
        @(posedge clk_pixel); #1;
        rst = 1'b0;
        pix(11'd100, 10'd300, BLACK, "post_reset_col0");
        pix(11'd190, 10'd300, BLACK, "post_reset_col1");
        pix(11'd100, 10'd279, BLACK, "post_reset_no_peak");

        // Zero velocity and peak: sampled rows stay black
        for (int i = 0; i < 3; i++) inst_velocity[i] = '0;
        frame();
        scan_row(10'd0,   "scan_row_0");
        scan_row(10'd280, "scan_row_280");
        scan_row(10'd500, "scan_row_500");
        scan_row(10'd680, "scan_row_680");
        scan_row(10'd719, "scan_row_719");

        // Peak hold and fall on instrument 2 (x 256..319)
        do_reset();
        inst_velocity[2] = 7'd80;
        frame();
        pix(11'd280, 10'd360, WHITE, "pk_set_marker");
        pix(11'd280, 10'd357, WHITE, "pk_set_marker_top");
        pix(11'd280, 10'd356, BLACK, "pk_set_above");
        pix(11'd280, 10'd361, BLUE,  "pk_set_bar");
        inst_velocity[2] = 7'd0;
        frames(30);
        pix(11'd280, 10'd360, WHITE, "pk_held_31_frames");
        pix(11'd280, 10'd361, BLACK, "pk_bar_gone");
        frame();
        pix(11'd280, 10'd360, BLACK, "pk_fall_old_row");
        pix(11'd280, 10'd364, WHITE, "pk_fall_79");
        frames(78);
        pix(11'd280, 10'd676, WHITE, "pk_at_1");
        frame();
        pix(11'd280, 10'd676, BLACK, "pk_zero_row676");
        pix(11'd280, 10'd680, BLACK, "pk_zero_no_marker");

        // Re-hit at equal velocity reloads the hold
        do_reset();
        inst_velocity[2] = 7'd60;
        frame();
        inst_velocity[2] = 7'd0;
        frames(40);
        pix(11'd280, 10'd480, WHITE, "rh_50_falling");
        inst_velocity[2] = 7'd50;
        frame();
        inst_velocity[2] = 7'd0;
        frame();
        pix(11'd280, 10'd480, WHITE, "rh_reload_hold");
        pix(11'd280, 10'd484, BLACK, "rh_reload_not_49");

        // Lower velocity during fall: peak follows but hold stays expired
        do_reset();
        inst_velocity[2] = 7'd60;
        frame();
        inst_velocity[2] = 7'd0;
        frames(40);
        inst_velocity[2] = 7'd49;
        frame();
        pix(11'd280, 10'd484, WHITE, "rh49_marker");
        pix(11'd280, 10'd485, BLUE,  "rh49_bar");
        inst_velocity[2] = 7'd0;
        frame();
        pix(11'd280, 10'd488, WHITE, "rh49_no_hold_48");
        pix(11'd280, 10'd484, BLACK, "rh49_old_row");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
